// File: rtl/rawp_stream_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rawp_stream_writer_pkg
// Brief    : Shared state encoding and raw-port constants for the ring writer.
// Revision : 1.0
// ============================================================================
`ifndef RING_WORDS
`define RING_WORDS(dl2) (1 << (dl2))
`endif

package rawp_stream_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } rawp_state_t;

  localparam int RAW_WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/rawp_ring_ptr.sv
`default_nettype none
// ============================================================================
// Module   : rawp_ring_ptr
// Brief    : Ring write pointer with full flag, registered fill level and IRQ.
// Revision : 1.0
// ============================================================================
module rawp_ring_ptr
  import rawp_stream_writer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_advance,
  input  logic [DEPTH_LOG2-1:0] i_rd_ptr,
  input  logic [DEPTH_LOG2:0]   i_thresh,
  output logic [DEPTH_LOG2-1:0] o_wr_ptr,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_irq
);

  localparam logic [DEPTH_LOG2-1:0] c_LAST = DEPTH_LOG2'(`RING_WORDS(DEPTH_LOG2) - 1);

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] w_wr_inc;
  logic [DEPTH_LOG2-1:0] w_used;
  logic [DEPTH_LOG2:0]   w_level;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_irq;

  assign w_wr_inc = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + DEPTH_LOG2'(1);
  // Modulo subtraction falls out of the DEPTH_LOG2-bit width.
  assign w_used   = r_wr_ptr - i_rd_ptr;
  assign w_level  = {1'b0, w_used};
  assign o_full   = (w_wr_inc == i_rd_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (i_clear) begin
        r_wr_ptr <= '0;
      end else if (i_advance) begin
        r_wr_ptr <= w_wr_inc;
      end
      r_level <= w_level;
      r_irq   <= (i_thresh != '0) && (w_level >= i_thresh);
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_level  = r_level;
  assign o_irq    = r_irq;

endmodule

`default_nettype wire

// File: rtl/rawp_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : rawp_stream_writer
// Brief    : Stream-to-ring DMA writer on the RAM raw port; RAWP_WRITER_DROP_EN
//            replaces backpressure with drop-when-full plus a drop counter.
// Revision : 1.0
// ============================================================================
module rawp_stream_writer
  import rawp_stream_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int BASE_WORD  = 0,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  rawp_clk,
  input  logic                  rawp_rst_n,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic [DEPTH_LOG2-1:0] rd_ptr_i,
  input  logic [DEPTH_LOG2:0]   thresh_i,
  input  logic [31:0]           s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [ADDR_WIDTH-1:0] rawp_adr_o,
  output logic [31:0]           rawp_dat_o,
  output logic                  rawp_we_o,
  input  logic                  rawp_stall_i,
  output logic [DEPTH_LOG2-1:0] wr_ptr_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  irq_o,
  output logic                  err_o,
  output logic                  busy_o
`ifdef RAWP_WRITER_DROP_EN
  ,
  output logic [15:0]           drop_cnt_o
`endif
);

  localparam int c_BYTE_SHIFT = $clog2(RAW_WORD_BYTES);
  localparam int c_WORD_W     = ADDR_WIDTH - c_BYTE_SHIFT;
  localparam logic [c_WORD_W-1:0]   c_BASE_WORD = c_WORD_W'(BASE_WORD);
  localparam logic [ADDR_WIDTH-1:0] c_BASE_ADR  = {c_BASE_WORD, {c_BYTE_SHIFT{1'b0}}};

  rawp_state_t           r_state;
  rawp_state_t           w_state_nxt;
  logic                  r_we;
  logic                  r_chk;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [31:0]           r_dat;
  logic [DEPTH_LOG2-1:0] w_wr_ptr;
  logic                  w_full;
  logic                  w_ready;
  logic                  w_hs;
  logic                  w_accept;
  logic                  w_advance;
  logic                  w_stall_err;
  logic [c_WORD_W-1:0]   w_word;

  rawp_ring_ptr #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ring_ptr (
    .clk      (rawp_clk),
    .rst_n    (rawp_rst_n),
    .i_clear  (clear_i),
    .i_advance(w_advance),
    .i_rd_ptr (rd_ptr_i),
    .i_thresh (thresh_i),
    .o_wr_ptr (w_wr_ptr),
    .o_full   (w_full),
    .o_level  (level_o),
    .o_irq    (irq_o)
  );

`ifdef RAWP_WRITER_DROP_EN
  logic       w_drop;
  logic [15:0] r_drop_cnt;

  assign w_ready  = (r_state == ST_RUN);
  assign w_accept = w_hs & ~w_full;
  assign w_drop   = w_hs & w_full;

  always_ff @(posedge rawp_clk or negedge rawp_rst_n) begin
    if (!rawp_rst_n) begin
      r_drop_cnt <= '0;
    end else if (clear_i) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt_o = r_drop_cnt;
`else
  assign w_ready  = (r_state == ST_RUN) & ~w_full;
  assign w_accept = w_hs;
`endif

  assign w_hs        = s_valid_i & w_ready;
  assign w_advance   = w_accept & ~clear_i;
  // r_chk marks the cycle in which the RAM reports on last cycle's write.
  assign w_stall_err = r_chk & rawp_stall_i;
  assign w_word      = c_BASE_WORD + c_WORD_W'(w_wr_ptr);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (enable_i && !r_err) w_state_nxt = ST_RUN;
      ST_RUN:   if (!enable_i) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_we) w_state_nxt = ST_IDLE;
      ST_ERR:   w_state_nxt = ST_ERR;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_stall_err) w_state_nxt = ST_ERR;
    if (clear_i)     w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge rawp_clk or negedge rawp_rst_n) begin
    if (!rawp_rst_n) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_chk   <= 1'b0;
      r_err   <= 1'b0;
      r_adr   <= c_BASE_ADR;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_advance;
      r_chk   <= r_we & ~clear_i;
      if (clear_i) begin
        r_err <= 1'b0;
      end else if (w_stall_err) begin
        r_err <= 1'b1;
      end
      if (w_advance) begin
        r_adr <= {w_word, {c_BYTE_SHIFT{1'b0}}};
        r_dat <= s_data_i;
      end
    end
  end

  assign s_ready_o  = w_ready;
  assign rawp_adr_o = r_adr;
  assign rawp_dat_o = r_dat;
  assign rawp_we_o  = r_we;
  assign wr_ptr_o   = w_wr_ptr;
  assign err_o      = r_err;
  assign busy_o     = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rawp_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rawp_stream_writer
// Brief    : Randomized scoreboard bench for rawp_stream_writer (4-word ring).
// Revision : 1.0
// ============================================================================
module tb_rawp_stream_writer;

  localparam int AW   = 11;
  localparam int BASE = 0;
  localparam int DL2  = 2;
  localparam int D    = 1 << DL2;

`ifdef RAWP_WRITER_DROP_EN
  localparam bit DROP = 1'b1;
  logic [15:0] drop_cnt;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] adr;
    logic [31:0]   dat;
  } wr_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en, clr, vld;
  logic [DL2-1:0] rd;
  logic [DL2:0]   th;
  logic [31:0]    din;
  logic           rdy, we, stall, irq, err, busy;
  logic [AW-1:0]  adr;
  logic [31:0]    dat;
  logic [DL2-1:0] wr_ptr;
  logic [DL2:0]   level;

  int n_chk = 0;
  int n_err = 0;
  int n_writes = 0;
  int ram_words = 512;

  // Reference model state
  wr_t exp_q[$];
  int  m_wr, m_level, m_drop;
  bit  m_run, m_irq, m_err, m_p1, m_p2;

  rawp_stream_writer #(
    .ADDR_WIDTH(AW),
    .BASE_WORD (BASE),
    .DEPTH_LOG2(DL2)
  ) dut (
    .rawp_clk    (clk),
    .rawp_rst_n  (rst_n),
    .enable_i    (en),
    .clear_i     (clr),
    .rd_ptr_i    (rd),
    .thresh_i    (th),
    .s_data_i    (din),
    .s_valid_i   (vld),
    .s_ready_o   (rdy),
    .rawp_adr_o  (adr),
    .rawp_dat_o  (dat),
    .rawp_we_o   (we),
    .rawp_stall_i(stall),
    .wr_ptr_o    (wr_ptr),
    .level_o     (level),
    .irq_o       (irq),
    .err_o       (err),
    .busy_o      (busy)
`ifdef RAWP_WRITER_DROP_EN
    ,
    .drop_cnt_o  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // RAM raw port: a write outside the populated RAM is flagged one cycle later.
  always @(posedge clk) stall <= we && (int'(adr >> 2) >= ram_words);

  // Behavioural model: one update per clock from the pre-edge inputs.
  always @(posedge clk or negedge rst_n) begin
    bit full, ready, hs, acc;
    if (!rst_n) begin
      m_wr = 0; m_level = 0; m_drop = 0;
      m_run = 0; m_irq = 0; m_err = 0; m_p1 = 0; m_p2 = 0;
      exp_q.delete();
    end else begin
      full    = ((m_wr + 1) % D) == int'(rd);
      ready   = m_run && (DROP || !full);
      hs      = vld && ready;
      acc     = hs && !full;
      m_level = (m_wr - int'(rd) + D) % D;
      m_irq   = (th != 0) && (m_level >= int'(th));
      if (clr) begin
        m_wr = 0; m_err = 0; m_p1 = 0; m_p2 = 0; m_run = 0; m_drop = 0;
      end else begin
        if (m_p2) m_err = 1;
        m_p2 = m_p1;
        m_p1 = acc && ((BASE + m_wr) >= ram_words);
        if (acc) begin
          exp_q.push_back('{adr: AW'((BASE + m_wr) * 4), dat: din});
          m_wr = (m_wr + 1) % D;
        end else if (hs && m_drop < 65535) begin
          m_drop = m_drop + 1;
        end
        m_run = en && !m_err;
      end
    end
  end

  // Monitor: write scoreboard plus per-cycle status comparison.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(adr), 64'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_adr", 64'(adr), 64'(e.adr));
          chk("write_dat", 64'(dat), 64'(e.dat));
        end
      end
      chk("s_ready", 64'(rdy), 64'(m_run && (DROP || (((m_wr + 1) % D) != int'(rd)))));
      chk("wr_ptr", 64'(wr_ptr), 64'(m_wr));
      chk("level", 64'(level), 64'(m_level));
      chk("irq", 64'(irq), 64'(m_irq));
      chk("err", 64'(err), 64'(m_err));
`ifdef RAWP_WRITER_DROP_EN
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
    end
  end

  initial begin
    int w0, cnt;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; vld = 1'b0;
    rd = '0; th = '0; din = '0; stall = 1'b0;

    // Reset values
    step(3);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_adr", 64'(adr), 64'(BASE * 4));
    chk("rst_dat", 64'(dat), 64'd0);
    chk("rst_ready", 64'(rdy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
    rst_n = 1'b1;

    // Two back-to-back words
    en = 1'b1;
    step(1);
    vld = 1'b1; din = 32'h1111_1111;
    step(1);
    din = 32'h2222_2222;
    step(1);
    vld = 1'b0;
    step(3);
    chk("p1_writes", 64'(n_writes), 64'd2);
    chk("p1_wr_ptr", 64'(wr_ptr), 64'd2);
    chk("p1_level", 64'(level), 64'd2);

    // Fill to full, then reopen via rd_ptr and wrap
    en = 1'b0;
    step(4);
    chk("p2_idle", 64'(busy), 64'd0);
    clr = 1'b1;
    step(1);
    clr = 1'b0; th = 3'd3; rd = '0; en = 1'b1;
    w0 = n_writes;
    step(1);
    vld = 1'b1;
    repeat (5) begin
      din = $urandom;
      step(1);
    end
    step(1);
    chk("p2_fill_writes", 64'(n_writes - w0), 64'd3);
    chk("p2_irq_full", 64'(irq), 64'd1);
`ifdef RAWP_WRITER_DROP_EN
    chk("p2_drop_cnt", 64'(drop_cnt), 64'd2);
`else
    chk("p2_ready_full", 64'(rdy), 64'd0);
`endif
    rd = 2'd2;
    repeat (4) begin
      din = $urandom;
      step(1);
    end
    vld = 1'b0;
    step(2);
    chk("p2_wrap_writes", 64'(n_writes - w0), 64'd5);
    chk("p2_wr_ptr_wrap", 64'(wr_ptr), 64'd1);
    rd = 2'd1;
    step(2);
    chk("p2_level_caught", 64'(level), 64'd0);
    chk("p2_irq_clear", 64'(irq), 64'd0);

    // Random bursts, each ended by dropping enable mid-burst
    for (int b = 0; b < 6; b++) begin
      en = 1'b0;
      step(4);
      en = 1'b1;
      step(1);
      for (int c = 0; c < 40; c++) begin
        vld = ($urandom_range(0, 3) != 0);
        din = $urandom;
        if ($urandom_range(0, 3) == 0) rd = DL2'($urandom_range(0, D - 1));
        if ($urandom_range(0, 15) == 0) th = (DL2 + 1)'($urandom_range(0, D));
        step(1);
      end
      vld = 1'b1; din = $urandom; en = 1'b0;
      step(1);
      vld = 1'b0;
      cnt = 1;
      while (busy && cnt < 6) begin
        step(1);
        cnt++;
      end
      chk("drain_bound", 64'(cnt <= 3), 64'd1);
      step(3);
      chk("drain_no_pending", 64'(exp_q.size()), 64'd0);
    end

    // Address error from a ring placed outside the populated RAM
    clr = 1'b1;
    step(1);
    clr = 1'b0; rd = '0; th = '0; ram_words = 0; en = 1'b1;
    step(1);
    vld = 1'b1; din = 32'hDEAD_BEEF;
    step(1);
    vld = 1'b0;
    cnt = 0;
    while (!err && cnt < 6) begin
      step(1);
      cnt++;
    end
    chk("err_set", 64'(err), 64'd1);
    chk("err_ready", 64'(rdy), 64'd0);
    chk("err_busy", 64'(busy), 64'd1);
    en = 1'b0;
    step(2);
    chk("err_sticky", 64'(err), 64'd1);
    clr = 1'b1;
    step(1);
    clr = 1'b0; ram_words = 512;
    chk("clr_err", 64'(err), 64'd0);
    chk("clr_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("clr_idle", 64'(busy), 64'd0);
    step(2);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rawp_stream_writer.md
Name: rawp_stream_writer

Overview:
- Ring-buffer DMA writer that drives port B (raw port) of the dual-port DMA RAM.
- Accepts a 32-bit valid/ready sample stream, for example frequency-counter capture words, and writes each word to consecutive RAM words inside a fixed ring region.
- Publishes write pointer, fill level and a threshold IRQ so the CPU can drain the ring over the Wishbone port and return its read pointer.

Parameters:
- ADDR_WIDTH, 11: byte-address width of the RAM raw port; bits [1:0] always driven 0.
- BASE_WORD, 0: first word index of the ring region inside the RAM.
- DEPTH_LOG2, 8: ring size = 2**DEPTH_LOG2 words; BASE_WORD + 2**DEPTH_LOG2 must not exceed the RAM word count.

Ports:
- rawp_clk  in  1  single clock, shared with the RAM raw port
- rawp_rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  run request from CSR
- clear_i  in  1  one-cycle pulse: zero pointers, clear error
- rd_ptr_i  in  DEPTH_LOG2  CPU read pointer, word index within ring
- thresh_i  in  DEPTH_LOG2+1  IRQ level threshold
- s_data_i  in  32  stream data
- s_valid_i  in  1  stream valid
- s_ready_o  out  1  stream ready
- rawp_adr_o  out  ADDR_WIDTH  RAM byte address
- rawp_dat_o  out  32  RAM write data
- rawp_we_o  out  1  RAM write enable
- rawp_stall_i  in  1  RAM bad-address flag, valid 1 cycle after address
- wr_ptr_o  out  DEPTH_LOG2  next word index to be written
- level_o  out  DEPTH_LOG2+1  words held, = wr_ptr - rd_ptr mod 2**DEPTH_LOG2
- irq_o  out  1  level_o >= thresh_i and thresh_i != 0
- err_o  out  1  sticky address error
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; wr_ptr=0; rawp_we_o=0; rawp_adr_o=BASE_WORD<<2; rawp_dat_o=0; s_ready_o=0; err_o=0; irq_o=0; level_o=0; busy_o=0.
- States:
  - IDLE -> RUN when enable_i=1 and err_o=0.
  - RUN -> DRAIN when enable_i=0.
  - DRAIN -> IDLE after any write issued in the previous cycle has its rawp_stall_i sampled (at most 2 cycles).
  - Any state -> ERR on rawp_stall_i=1 while a write is pending check.
  - ERR -> IDLE only on clear_i.
- full = (wr_ptr + 1) mod 2**DEPTH_LOG2 == rd_ptr_i. One slot always stays empty, so level_o max = 2**DEPTH_LOG2 - 1.
- s_ready_o = (state==RUN) & ~full. It is combinational from registered state and ptrs plus rd_ptr_i.
- Handshake at cycle N (s_valid_i & s_ready_o):
  - At N+1: rawp_we_o=1, rawp_dat_o=s_data_i, rawp_adr_o=(BASE_WORD+wr_ptr)<<2, wr_ptr incremented (wraps to 0 after 2**DEPTH_LOG2-1).
  - rawp_stall_i for that write is sampled at N+2.
  - Throughput is 1 word/cycle.
  - rawp_we_o=0 in any cycle with no handshake in the previous cycle.
- Error: on rawp_stall_i=1 the block sets err_o, enters ERR, and holds s_ready_o=0. wr_ptr is left advanced; software must clear.
- clear_i: wr_ptr=0, err_o=0, state=IDLE, rawp_we_o=0 next cycle. An in-flight handshake in the same cycle is discarded. clear_i wins over a simultaneous handshake.
- level_o and irq_o are registered one cycle after wr_ptr and rd_ptr_i change.
- rd_ptr_i changing while full reopens s_ready_o in the same cycle.
- enable_i dropping in the same cycle as a handshake: the word is accepted and written; DRAIN follows.

Optional Feature:
- Macro RAWP_WRITER_DROP_EN.
- Defined: in RUN, s_ready_o=1 regardless of full. Words arriving while full are discarded, with no RAM write and no ptr change. A 16-bit saturating drop_cnt_o output port is present, cleared by clear_i and reset.
- Undefined: backpressure via s_ready_o as above; drop_cnt_o port absent.

Decomposition:
- Shared package/include holds: state encodings (IDLE=0, RUN=1, DRAIN=2, ERR=3), the RAW_WORD_BYTES=4 constant, and the derived RING_WORDS = 1<<DEPTH_LOG2 macro.
- One sub-module is natural: rawp_ring_ptr, which holds wr_ptr, computes full, level and irq, and handles wrap. It is reusable by a future read-side stream reader.

Test Plan:
- Reset, enable, push 0x11111111, 0x22222222 back-to-back:
  - rawp_we_o high 2 cycles.
  - Byte addresses 0x000, 0x004.
  - wr_ptr_o=2, level_o=2 with rd_ptr_i=0.
- DEPTH_LOG2=2, rd_ptr_i=0, continuous valid:
  - Exactly 3 writes, then s_ready_o=0.
  - Set rd_ptr_i=2 -> 2 more writes at 0x00C, 0x000; wr_ptr wraps 3->0->1.
- thresh_i=3: irq_o asserts one cycle after the 3rd write's wr_ptr update; deasserts after rd_ptr_i catches up.
- BASE_WORD beyond RAM so RAM returns rawp_stall_i=1: err_o=1 at N+2, s_ready_o=0; clear_i -> err_o=0, wr_ptr_o=0, IDLE.
- Drop enable_i during a valid burst: last accepted word is written; busy_o falls within 2 cycles; no further rawp_we_o.
- With RAWP_WRITER_DROP_EN and DEPTH_LOG2=2: push 5 words with rd_ptr_i=0 -> 3 written, drop_cnt_o=2.
